// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester, memory and display signals of the data-memory port arbiter
// slave is the arbiter's view; master is the view of the blocks around it.
interface dmem_port_arbiter_if;
  logic        cpu_re;
  logic        cpu_we;
  logic [31:0] cpu_a;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_stall;
  logic        kb_valid;
  logic [7:0]  kb_code;
  logic        kb_overflow;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [31:0] money;
  logic [31:0] sym;
  logic        disp_valid;

  modport slave (
    input  cpu_re, cpu_we, cpu_a, cpu_wd,
    output cpu_rd, cpu_stall,
    input  kb_valid, kb_code,
    output kb_overflow,
    output mem_we, mem_a, mem_wd,
    input  mem_rd,
    output money, sym, disp_valid
  );

  modport master (
    output cpu_re, cpu_we, cpu_a, cpu_wd,
    input  cpu_rd, cpu_stall,
    output kb_valid, kb_code,
    input  kb_overflow,
    input  mem_we, mem_a, mem_wd,
    output mem_rd,
    input  money, sym, disp_valid
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data-memory port between CPU, PS/2 key writer and VGA refresher
// The CPU wins by default; an aged background request takes exactly one cycle from it.
module dmem_port_arbiter #(
  parameter logic [31:0] KB_ADDR        = 32'd10,
  parameter logic [31:0] MONEY_ADDR     = 32'd20,
  parameter logic [31:0] SYM_ADDR       = 32'd24,
  parameter int          REFRESH_CYCLES = 1024,
  parameter int          STARVE_LIMIT   = 8
) (
  input  logic               clk,
  input  logic               rstin,
  dmem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_MONEY = 2'd1;
  localparam logic [1:0] R_SYM   = 2'd2;

  logic [7:0]       fifo0_q, fifo0_d;
  logic [7:0]       fifo1_q, fifo1_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;
  logic             kb_overflow_q, kb_overflow_d;
  logic [AGE_W-1:0] kb_age_q, kb_age_d;
  logic [AGE_W-1:0] ref_age_q, ref_age_d;
  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [31:0]      money_q, money_d;
  logic [31:0]      sym_q, sym_d;
  logic             disp_valid_q, disp_valid_d;

  logic       cpu_req;
  logic       fifo_nempty;
  logic       ref_pending;
  logic [7:0] fifo_head;
  logic       kb_forced;
  logic       ref_forced;
  logic       kb_grant;
  logic       ref_grant;
  logic       cpu_grant;
  logic       push_ok;

  assign cpu_req     = bus.cpu_re | bus.cpu_we;
  assign fifo_nempty = (fifo_cnt_q != 2'd0);
  assign ref_pending = (phase_q != R_IDLE);
  assign fifo_head   = rd_ptr_q ? fifo1_q : fifo0_q;
  assign kb_forced   = fifo_nempty && (kb_age_q >= AGE_LIMIT);
  assign ref_forced  = ref_pending && (ref_age_q >= AGE_LIMIT);

  // Fixed priority; only registered FIFO occupancy counts, so a key is never granted in its push cycle.
  always_comb begin
    kb_grant  = 1'b0;
    ref_grant = 1'b0;
    cpu_grant = 1'b0;
    if (kb_forced) begin
      kb_grant = 1'b1;
    end else if (ref_forced) begin
      ref_grant = 1'b1;
    end else if (cpu_req) begin
      cpu_grant = 1'b1;
    end else if (fifo_nempty) begin
      kb_grant = 1'b1;
    end else if (ref_pending) begin
      ref_grant = 1'b1;
    end
  end

  always_comb begin
    bus.mem_we = 1'b0;
    bus.mem_a  = 32'd0;
    bus.mem_wd = 32'd0;
    if (kb_grant) begin
      bus.mem_we = 1'b1;
      bus.mem_a  = KB_ADDR;
      bus.mem_wd = {24'd0, fifo_head};
    end else if (ref_grant) begin
      bus.mem_a  = (phase_q == R_MONEY) ? MONEY_ADDR : SYM_ADDR;
    end else if (cpu_grant) begin
      bus.mem_we = bus.cpu_we;
      bus.mem_a  = bus.cpu_a;
      bus.mem_wd = bus.cpu_wd;
    end
  end

  assign bus.cpu_rd      = cpu_grant ? bus.mem_rd : 32'd0;
  assign bus.cpu_stall   = cpu_req & ~cpu_grant;
  assign bus.kb_overflow = kb_overflow_q;
  assign bus.money       = money_q;
  assign bus.sym         = sym_q;
  assign bus.disp_valid  = disp_valid_q;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = bus.kb_valid && ((fifo_cnt_q != 2'd2) || kb_grant);

  always_comb begin
    fifo0_d       = fifo0_q;
    fifo1_d       = fifo1_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    kb_overflow_d = kb_overflow_q | (bus.kb_valid & ~push_ok);
    if (push_ok) begin
      if (wr_ptr_q) begin
        fifo1_d = bus.kb_code;
      end else begin
        fifo0_d = bus.kb_code;
      end
      wr_ptr_d = ~wr_ptr_q;
    end
    if (kb_grant) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, kb_grant})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    kb_age_d = kb_age_q;
    if (kb_grant || !fifo_nempty) begin
      kb_age_d = '0;
    end else if (kb_age_q != AGE_LIMIT) begin
      kb_age_d = kb_age_q + AGE_ONE;
    end
    ref_age_d = ref_age_q;
    if (ref_grant || !ref_pending) begin
      ref_age_d = '0;
    end else if (ref_age_q != AGE_LIMIT) begin
      ref_age_d = ref_age_q + AGE_ONE;
    end
  end

  // Refresh runs free; a terminal count while a refresh is still in flight is simply lost.
  always_comb begin
    ref_cnt_d    = (ref_cnt_q == CNT_LAST) ? '0 : ref_cnt_q + CNT_ONE;
    phase_d      = phase_q;
    money_d      = money_q;
    sym_d        = sym_q;
    disp_valid_d = 1'b0;
    case (phase_q)
      R_IDLE: begin
        if (ref_cnt_q == CNT_LAST) begin
          phase_d = R_MONEY;
        end
      end
      R_MONEY: begin
        if (ref_grant) begin
          money_d = bus.mem_rd;
          phase_d = R_SYM;
        end
      end
      R_SYM: begin
        if (ref_grant) begin
          sym_d        = bus.mem_rd;
          disp_valid_d = 1'b1;
          phase_d      = R_IDLE;
        end
      end
      default: phase_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      fifo0_q       <= 8'd0;
      fifo1_q       <= 8'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      kb_overflow_q <= 1'b0;
      kb_age_q      <= '0;
      ref_age_q     <= '0;
      ref_cnt_q     <= '0;
      phase_q       <= R_IDLE;
      money_q       <= 32'd0;
      sym_q         <= 32'd0;
      disp_valid_q  <= 1'b0;
    end else begin
      fifo0_q       <= fifo0_d;
      fifo1_q       <= fifo1_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      kb_overflow_q <= kb_overflow_d;
      kb_age_q      <= kb_age_d;
      ref_age_q     <= ref_age_d;
      ref_cnt_q     <= ref_cnt_d;
      phase_q       <= phase_d;
      money_q       <= money_d;
      sym_q         <= sym_d;
      disp_valid_q  <= disp_valid_d;
    end
  end

endmodule
